// File: rtl/matmul_tile_accumulator.sv
// matmul_tile_accumulator
// Sequences a stream of A/B operand tiles into an external combinational
// M x N x K multiply-accumulate array. The accumulator feeds the array's C
// input, and the array's D output is captured back into it. After the
// programmed number of K-tiles, the final M x N sum is offered on a
// valid/ready result port.
module matmul_tile_accumulator #(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int K  = 2,
    parameter int P  = 8,
    parameter int TW = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [TW-1:0]                     num_tiles,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [M-1:0][K-1:0][P-1:0]        a_in,
    input  logic [K-1:0][N-1:0][P-1:0]        b_in,
    output logic [M-1:0][K-1:0][P-1:0]        a_out,
    output logic [K-1:0][N-1:0][P-1:0]        b_out,
    output logic [M-1:0][N-1:0][4*P-1:0]      c_out,
    input  logic [M-1:0][N-1:0][4*P-1:0]      d_in,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [M-1:0][N-1:0][4*P-1:0]      res_data,
    output logic                              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         state_r;
    logic [TW-1:0]                  tgt_r;
    logic [TW-1:0]                  cnt_r;
    logic                           pending_r;
    logic [M-1:0][N-1:0][4*P-1:0]   acc_r;

    // The array always sees the live accumulator; the result port is the same
    // register, so it is stable for as long as the FSM sits in DONE.
    assign c_out    = acc_r;
    assign res_data = acc_r;

    // Job sequencing FSM: operand registers, tile counting, accumulator
    // capture and all handshake outputs are updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            tgt_r     <= {TW{1'b0}};
            cnt_r     <= {TW{1'b0}};
            pending_r <= 1'b0;
            acc_r     <= '0;
            a_out     <= '0;
            b_out     <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        tgt_r     <= num_tiles;
                        cnt_r     <= {TW{1'b0}};
                        acc_r     <= '0;
                        pending_r <= 1'b0;
                        busy      <= 1'b1;
                        if (num_tiles == {TW{1'b0}}) begin
                            // Empty job: the all-zero accumulator is the answer.
                            state_r   <= DONE;
                            res_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state_r   <= RUN;
                            res_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // d_in reflects the operands registered one edge ago.
                    if (pending_r) begin
                        acc_r <= d_in;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (in_valid && in_ready) begin
                        a_out     <= a_in;
                        b_out     <= b_in;
                        cnt_r     <= cnt_r + TW'(1'b1);
                        pending_r <= 1'b1;
                        if (cnt_r + TW'(1'b1) == tgt_r) begin
                            state_r  <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state_r  <= RUN;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        pending_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Fold in the last tile, then present the result.
                    acc_r     <= d_in;
                    pending_r <= 1'b0;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state_r   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pending_r <= 1'b0;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
